// File: rtl/wb_regfile_if.sv
// wb_regfile_if: groups the MEM/WB write-back, decode read-port and load
// scoreboard signals of the write-back stage into one bundle.
//   master : pipeline side (drives write-back, read indices, load issue)
//   slave  : wb_regfile side (returns operands, write-back value, stall,
//            retire count)
interface wb_regfile_if #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned COUNT_WIDTH = 32
);
   localparam int unsigned AW = 5;

   logic [WIDTH-1:0]       ALUResult;
   logic [WIDTH-1:0]       ReadDataDM;
   logic                   MemToReg;
   logic                   RegWrite;
   logic [AW-1:0]          WriteRegister;
   logic [AW-1:0]          ReadRegister1;
   logic [AW-1:0]          ReadRegister2;
   logic [WIDTH-1:0]       ReadData1;
   logic [WIDTH-1:0]       ReadData2;
   logic                   PendSet;
   logic [AW-1:0]          PendRegister;
   logic                   Stall;
   logic [WIDTH-1:0]       WriteData;
   logic [COUNT_WIDTH-1:0] RetireCount;

   modport master (
      output ALUResult, ReadDataDM, MemToReg, RegWrite, WriteRegister,
             ReadRegister1, ReadRegister2, PendSet, PendRegister,
      input  ReadData1, ReadData2, Stall, WriteData, RetireCount
   );

   modport slave (
      input  ALUResult, ReadDataDM, MemToReg, RegWrite, WriteRegister,
             ReadRegister1, ReadRegister2, PendSet, PendRegister,
      output ReadData1, ReadData2, Stall, WriteData, RetireCount
   );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux, 32 x WIDTH architectural register file with
// two write-through read ports, load scoreboard producing a decode stall,
// and a retired-write counter.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-low reset
//   bus  - wb_regfile_if.slave:
//          in : ALUResult, ReadDataDM, MemToReg, RegWrite, WriteRegister,
//               ReadRegister1/2, PendSet, PendRegister
//          out: ReadData1/2 (comb), Stall (comb), WriteData (comb),
//               RetireCount (registered)
module wb_regfile #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned COUNT_WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   wb_regfile_if.slave  bus
);
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;

   logic [WIDTH-1:0]       regs [NREGS];
   logic [NREGS-1:0]       pend;
   logic [NREGS-1:0]       pend_nxt;
   logic [COUNT_WIDTH-1:0] retire_cnt;

   logic             commit_c;
   logic             clr1_c;
   logic             clr2_c;
   logic [WIDTH-1:0] wdata_c;

   // Write-back select and commit qualification
   always_comb begin
      wdata_c  = bus.MemToReg ? bus.ReadDataDM : bus.ALUResult;
      commit_c = bus.RegWrite && (bus.WriteRegister != AW'(0));
   end

   assign bus.WriteData = wdata_c;

   // Read ports: r0 hardwired to zero, then same-cycle bypass, then storage
   always_comb begin
      bus.ReadData1 = '0;
      bus.ReadData2 = '0;
      if (bus.ReadRegister1 != AW'(0)) begin
         if (commit_c && (bus.WriteRegister == bus.ReadRegister1))
            bus.ReadData1 = wdata_c;
         else
            bus.ReadData1 = regs[bus.ReadRegister1];
      end
      if (bus.ReadRegister2 != AW'(0)) begin
         if (commit_c && (bus.WriteRegister == bus.ReadRegister2))
            bus.ReadData2 = wdata_c;
         else
            bus.ReadData2 = regs[bus.ReadRegister2];
      end
   end

   // A load committing to a source this cycle is covered by the bypass
   always_comb begin
      clr1_c = commit_c && bus.MemToReg && (bus.WriteRegister == bus.ReadRegister1);
      clr2_c = commit_c && bus.MemToReg && (bus.WriteRegister == bus.ReadRegister2);
      bus.Stall = (pend[bus.ReadRegister1] && (bus.ReadRegister1 != AW'(0)) && !clr1_c) ||
                  (pend[bus.ReadRegister2] && (bus.ReadRegister2 != AW'(0)) && !clr2_c);
   end

   // Scoreboard next state: clear first so a same-register set wins
   always_comb begin
      pend_nxt = pend;
      if (commit_c && bus.MemToReg)
         pend_nxt[bus.WriteRegister] = 1'b0;
      if (bus.PendSet && (bus.PendRegister != AW'(0)))
         pend_nxt[bus.PendRegister] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   // Register storage
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (commit_c) begin
         regs[bus.WriteRegister] <= wdata_c;
      end
   end

   // Scoreboard and retire counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend       <= '0;
         retire_cnt <= '0;
      end else begin
         pend <= pend_nxt;
         if (commit_c)
            retire_cnt <= retire_cnt + COUNT_WIDTH'(1);
      end
   end

   assign bus.RetireCount = retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile. Inputs change
// 1 time unit after a rising edge; outputs are sampled 1 unit later, well
// away from the next edge. The counter is built 4 bits wide so wrap is
// reachable.
module tb_wb_regfile;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned CW    = 4;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   int   exp_cnt;

   wb_regfile_if #(.WIDTH(WIDTH), .COUNT_WIDTH(CW)) bus ();

   wb_regfile #(.WIDTH(WIDTH), .COUNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 1 unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.ALUResult     = '0;
      bus.ReadDataDM    = '0;
      bus.MemToReg      = 1'b0;
      bus.RegWrite      = 1'b0;
      bus.WriteRegister = '0;
      bus.ReadRegister1 = '0;
      bus.ReadRegister2 = '0;
      bus.PendSet       = 1'b0;
      bus.PendRegister  = '0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_assert = 0;
      n_fail   = 0;
      exp_cnt  = 0;
      idle();
      rst = 1'b0;

      // Reset held for two edges
      tick();
      tick();
      bus.ReadRegister2 = 5'd4;
      #1;
      chk("reset_stall", 32'(bus.Stall), 32'd0);
      chk("reset_rd2", bus.ReadData2, 32'd0);
      rst = 1'b1;
      tick();
      for (int r = 1; r < 32; r++) begin
         bus.ReadRegister1 = 5'(r);
         bus.ReadRegister2 = 5'(r);
         #1;
         chk($sformatf("reset_rd1_r%0d", r), bus.ReadData1, 32'd0);
         chk($sformatf("reset_rd2_r%0d", r), bus.ReadData2, 32'd0);
      end
      chk("reset_cnt", 32'(bus.RetireCount), 32'd0);
      chk("reset_stall2", 32'(bus.Stall), 32'd0);

      // ALU commit to r5 with same-cycle read
      idle();
      bus.ALUResult     = 32'hDEADBEEF;
      bus.ReadDataDM    = 32'h11111111;
      bus.RegWrite      = 1'b1;
      bus.WriteRegister = 5'd5;
      bus.ReadRegister1 = 5'd5;
      #1;
      chk("alu_wdata", bus.WriteData, 32'hDEADBEEF);
      chk("alu_bypass", bus.ReadData1, 32'hDEADBEEF);
      tick();
      bus.RegWrite = 1'b0;
      #1;
      chk("alu_stored", bus.ReadData1, 32'hDEADBEEF);
      chk("alu_cnt", 32'(bus.RetireCount), 32'd1);

      // Load commit to r5
      bus.ALUResult     = 32'h0BADF00D;
      bus.ReadDataDM    = 32'h12345678;
      bus.MemToReg      = 1'b1;
      bus.RegWrite      = 1'b1;
      bus.WriteRegister = 5'd5;
      bus.ReadRegister2 = 5'd5;
      #1;
      chk("ld_wdata", bus.WriteData, 32'h12345678);
      chk("ld_bypass2", bus.ReadData2, 32'h12345678);
      tick();
      bus.RegWrite = 1'b0;
      #1;
      chk("ld_stored1", bus.ReadData1, 32'h12345678);
      chk("ld_cnt", 32'(bus.RetireCount), 32'd2);

      // Mux follows inputs without RegWrite, and nothing is stored
      idle();
      bus.ALUResult     = 32'hA5A5A5A5;
      bus.WriteRegister = 5'd6;
      bus.ReadRegister1 = 5'd6;
      #1;
      chk("nowr_wdata", bus.WriteData, 32'hA5A5A5A5);
      chk("nowr_nobypass", bus.ReadData1, 32'd0);
      tick();
      chk("nowr_stored", bus.ReadData1, 32'd0);
      chk("nowr_cnt", 32'(bus.RetireCount), 32'd2);

      // Register 0 writes are dropped and not counted
      idle();
      bus.ALUResult     = 32'hFFFFFFFF;
      bus.RegWrite      = 1'b1;
      bus.WriteRegister = 5'd0;
      bus.ReadRegister1 = 5'd0;
      #1;
      chk("r0_bypass", bus.ReadData1, 32'd0);
      tick();
      bus.RegWrite = 1'b0;
      #1;
      chk("r0_read", bus.ReadData1, 32'd0);
      chk("r0_cnt", 32'(bus.RetireCount), 32'd2);
      bus.PendSet      = 1'b1;
      bus.PendRegister = 5'd0;
      tick();
      bus.PendSet = 1'b0;
      #1;
      chk("r0_pend_stall", 32'(bus.Stall), 32'd0);

      // Load-use stall on r8 through port 2
      idle();
      bus.PendSet       = 1'b1;
      bus.PendRegister  = 5'd8;
      bus.ReadRegister2 = 5'd8;
      #1;
      chk("lu_pre", 32'(bus.Stall), 32'd0);
      tick();
      bus.PendSet = 1'b0;
      #1;
      chk("lu_n1", 32'(bus.Stall), 32'd1);
      tick();
      chk("lu_n2", 32'(bus.Stall), 32'd1);
      tick();
      bus.ReadDataDM    = 32'hCAFE0008;
      bus.MemToReg      = 1'b1;
      bus.RegWrite      = 1'b1;
      bus.WriteRegister = 5'd8;
      #1;
      chk("lu_n3_stall", 32'(bus.Stall), 32'd0);
      chk("lu_n3_rd2", bus.ReadData2, 32'hCAFE0008);
      tick();
      bus.RegWrite = 1'b0;
      #1;
      chk("lu_after_stall", 32'(bus.Stall), 32'd0);
      chk("lu_after_rd2", bus.ReadData2, 32'hCAFE0008);
      chk("lu_cnt", 32'(bus.RetireCount), 32'd3);

      // ALU commit does not clear a pending load (port 1)
      idle();
      bus.PendSet       = 1'b1;
      bus.PendRegister  = 5'd10;
      bus.ReadRegister1 = 5'd10;
      tick();
      bus.PendSet       = 1'b0;
      bus.ALUResult     = 32'h00000A0A;
      bus.RegWrite      = 1'b1;
      bus.WriteRegister = 5'd10;
      #1;
      chk("alu_noclr_stall", 32'(bus.Stall), 32'd1);
      tick();
      bus.RegWrite = 1'b0;
      #1;
      chk("alu_noclr_after", 32'(bus.Stall), 32'd1);
      chk("alu_noclr_cnt", 32'(bus.RetireCount), 32'd4);
      bus.ReadDataDM    = 32'h0000B0B0;
      bus.MemToReg      = 1'b1;
      bus.RegWrite      = 1'b1;
      bus.WriteRegister = 5'd10;
      #1;
      chk("p1_clr_stall", 32'(bus.Stall), 32'd0);
      chk("p1_clr_rd1", bus.ReadData1, 32'h0000B0B0);
      tick();
      bus.RegWrite = 1'b0;
      #1;
      chk("p1_clr_after", 32'(bus.Stall), 32'd0);
      chk("p1_clr_cnt", 32'(bus.RetireCount), 32'd5);

      // Same-register set and clear: set wins
      idle();
      bus.ReadDataDM    = 32'h00000099;
      bus.MemToReg      = 1'b1;
      bus.RegWrite      = 1'b1;
      bus.WriteRegister = 5'd9;
      bus.PendSet       = 1'b1;
      bus.PendRegister  = 5'd9;
      bus.ReadRegister1 = 5'd9;
      #1;
      chk("sc_same_pre", 32'(bus.Stall), 32'd0);
      tick();
      bus.RegWrite = 1'b0;
      bus.PendSet  = 1'b0;
      #1;
      chk("sc_same_stall", 32'(bus.Stall), 32'd1);
      chk("sc_same_rd1", bus.ReadData1, 32'h00000099);
      chk("sc_same_cnt", 32'(bus.RetireCount), 32'd6);

      // Different-register set and clear both take effect
      idle();
      bus.PendSet      = 1'b1;
      bus.PendRegister = 5'd11;
      tick();
      bus.ReadDataDM    = 32'h00000111;
      bus.MemToReg      = 1'b1;
      bus.RegWrite      = 1'b1;
      bus.WriteRegister = 5'd11;
      bus.PendRegister  = 5'd12;
      tick();
      idle();
      bus.ReadRegister1 = 5'd11;
      #1;
      chk("sc_diff_clr", 32'(bus.Stall), 32'd0);
      bus.ReadRegister1 = 5'd0;
      bus.ReadRegister2 = 5'd12;
      #1;
      chk("sc_diff_set", 32'(bus.Stall), 32'd1);
      chk("sc_diff_cnt", 32'(bus.RetireCount), 32'd7);

      // Reset mid-load overrides a simultaneous commit; late commit still lands
      idle();
      rst               = 1'b0;
      bus.ALUResult     = 32'h00000077;
      bus.RegWrite      = 1'b1;
      bus.WriteRegister = 5'd7;
      bus.ReadRegister1 = 5'd7;
      bus.ReadRegister2 = 5'd9;
      #1;
      chk("rst_bypass", bus.ReadData1, 32'h00000077);
      tick();
      bus.RegWrite = 1'b0;
      #1;
      chk("rst_rd1", bus.ReadData1, 32'd0);
      chk("rst_stall", 32'(bus.Stall), 32'd0);
      chk("rst_cnt", 32'(bus.RetireCount), 32'd0);
      rst = 1'b1;
      tick();
      chk("rst_pend_clr", 32'(bus.Stall), 32'd0);
      bus.ReadDataDM    = 32'h00001234;
      bus.MemToReg      = 1'b1;
      bus.RegWrite      = 1'b1;
      bus.WriteRegister = 5'd9;
      bus.ReadRegister1 = 5'd9;
      tick();
      bus.RegWrite = 1'b0;
      #1;
      chk("late_rd1", bus.ReadData1, 32'h00001234);
      chk("late_cnt", 32'(bus.RetireCount), 32'd1);

      // Counter wrap: 17 commits to r3 from a fresh reset
      idle();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      bus.ReadRegister1 = 5'd3;
      exp_cnt = 0;
      for (int k = 1; k <= 17; k++) begin
         bus.ALUResult     = 32'(k);
         bus.RegWrite      = 1'b1;
         bus.WriteRegister = 5'd3;
         tick();
         exp_cnt = (exp_cnt + 1) % 16;
         bus.RegWrite = 1'b0;
         #1;
         chk($sformatf("wrap_cnt_%0d", k), 32'(bus.RetireCount), 32'(exp_cnt));
      end
      chk("wrap_r3", bus.ReadData1, 32'd17);
      chk("wrap_final", 32'(bus.RetireCount), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
